// File: rtl/post_acc_quantizer.sv
// post_acc_quantizer: bias, activation and int8 requantization after the accumulator.
// Define POST_ACC_SAT_COUNT_EN to enable the clipped-lane counter on sat_count.
module post_acc_quantizer #(
    parameter int FIFO_DEPTH = 4,
    parameter int SHIFT_W    = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               valid_in,
    input  logic [31:0]        acc_col0_in,
    input  logic [31:0]        acc_col1_in,
    input  logic [1:0]         cfg_act_mode,
    input  logic [31:0]        cfg_bias0,
    input  logic [31:0]        cfg_bias1,
    input  logic [15:0]        cfg_scale,
    input  logic [SHIFT_W-1:0] cfg_shift,
    input  logic               out_ready,
    output logic               out_valid,
    output logic signed [7:0]  out_col0,
    output logic signed [7:0]  out_col1,
    output logic               almost_full,
    output logic               overflow,
    output logic [15:0]        sat_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    function automatic logic signed [32:0] activate(
        input logic signed [32:0] v,
        input logic [1:0]         mode
    );
        logic signed [32:0] r;
        r = v;
        unique case (1'b1)
            (mode == 2'b01 && v[32]): r = '0;
            (mode == 2'b10 && v[32]): r = v >>> 3;
            default:                  r = v;
        endcase
        return r;
    endfunction

    function automatic logic signed [49:0] requant(
        input logic signed [32:0] v,
        input logic [15:0]        scale,
        input logic [SHIFT_W-1:0] sh
    );
        logic signed [49:0] p;
        p = $signed({{17{v[32]}}, v}) * $signed({34'd0, scale});
        if (sh != '0)
            p = p + (50'sd1 <<< (sh - SHIFT_W'(1)));
        return p >>> sh;
    endfunction

    function automatic logic [7:0] clip8(input logic signed [49:0] r);
        if (r > 50'sd127)
            return 8'h7f;
        else if (r < -50'sd128)
            return 8'h80;
        else
            return r[7:0];
    endfunction

    logic                     s1_valid;
    logic signed [32:0]       s1_sum0, s1_sum1;
    logic [1:0]               s1_mode;
    logic [15:0]              s1_scale;
    logic [SHIFT_W-1:0]       s1_shift;

    logic                     s2_valid;
    logic signed [32:0]       s2_act0, s2_act1;
    logic [15:0]              s2_scale;
    logic [SHIFT_W-1:0]       s2_shift;

    logic                     s3_valid;
    logic [7:0]               s3_q0, s3_q1;

    logic signed [49:0]       rq0, rq1;

    logic [15:0]              mem [FIFO_DEPTH];
    logic [AW-1:0]            wr_ptr, rd_ptr;
    logic [CW-1:0]            count;
    logic [CW:0]              occ;
    logic                     full, do_push, do_pop;

    assign rq0 = requant(s2_act0, s2_scale, s2_shift);
    assign rq1 = requant(s2_act1, s2_scale, s2_shift);

    // Stage valids: flushed by reset/clear, otherwise free-running.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s3_valid <= 1'b0;
        end else begin
            s1_valid <= valid_in;
            s2_valid <= s1_valid;
            s3_valid <= s2_valid;
        end
    end

    // Datapath: bias add, activation, requantize; config rides with the beat.
    always_ff @(posedge clk) begin
        s1_sum0  <= $signed({acc_col0_in[31], acc_col0_in})
                  + $signed({cfg_bias0[31], cfg_bias0});
        s1_sum1  <= $signed({acc_col1_in[31], acc_col1_in})
                  + $signed({cfg_bias1[31], cfg_bias1});
        s1_mode  <= cfg_act_mode;
        s1_scale <= cfg_scale;
        s1_shift <= cfg_shift;
        s2_act0  <= activate(s1_sum0, s1_mode);
        s2_act1  <= activate(s1_sum1, s1_mode);
        s2_scale <= s1_scale;
        s2_shift <= s1_shift;
        s3_q0    <= clip8(rq0);
        s3_q1    <= clip8(rq1);
    end

    assign full      = (count == CW'(FIFO_DEPTH));
    assign out_valid = (count != '0);
    assign do_pop    = out_valid && out_ready;
    assign do_push   = s3_valid && (!full || do_pop);

    assign occ = {1'b0, count} + (CW+1)'(s1_valid)
               + (CW+1)'(s2_valid) + (CW+1)'(s3_valid);
    assign almost_full = (occ >= (CW+1)'(FIFO_DEPTH));

    assign out_col0 = out_valid ? mem[rd_ptr][7:0]  : '0;
    assign out_col1 = out_valid ? mem[rd_ptr][15:8] : '0;

    // FIFO storage: both columns of a beat share one entry.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= {s3_q1, s3_q0};
    end

    // FIFO pointers, occupancy and sticky drop flag.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)
                count <= count + CW'(1);
            else if (!do_push && do_pop)
                count <= count - CW'(1);
            if (s3_valid && !do_push)
                overflow <= 1'b1;
        end
    end

`ifdef POST_ACC_SAT_COUNT_EN
    logic [1:0]  s3_clip;
    logic [16:0] sat_sum;

    assign sat_sum = {1'b0, sat_count}
                   + 17'(s3_clip[0]) + 17'(s3_clip[1]);

    // Per-lane clip flags travel with the S3 result.
    always_ff @(posedge clk) begin
        s3_clip[0] <= (rq0 > 50'sd127) || (rq0 < -50'sd128);
        s3_clip[1] <= (rq1 > 50'sd127) || (rq1 < -50'sd128);
    end

    // Saturating count of clipped lanes, counted even if the beat is dropped.
    always_ff @(posedge clk) begin
        if (reset || clear)
            sat_count <= '0;
        else if (s3_valid)
            sat_count <= sat_sum[16] ? 16'hffff : sat_sum[15:0];
    end
`else
    assign sat_count = '0;
`endif

endmodule

// File: tb/tb_post_acc_quantizer.sv
// tb_post_acc_quantizer: directed scoreboard bench for post_acc_quantizer.
// Checks latency, math, backpressure, overflow and flush behaviour.
module tb_post_acc_quantizer;

    logic        clk = 1'b0;
    logic        reset, clear, valid_in, out_ready;
    logic [31:0] acc0, acc1, bias0, bias1;
    logic [1:0]  mode;
    logic [15:0] scale;
    logic [4:0]  shift;
    logic        out_valid, almost_full, overflow;
    logic [7:0]  out_col0, out_col1;
    logic [15:0] sat_count;

    int total = 0;
    int bad   = 0;
    logic [15:0] q[$];

    post_acc_quantizer #(.FIFO_DEPTH(4), .SHIFT_W(5)) dut (
        .clk(clk), .reset(reset), .clear(clear), .valid_in(valid_in),
        .acc_col0_in(acc0), .acc_col1_in(acc1), .cfg_act_mode(mode),
        .cfg_bias0(bias0), .cfg_bias1(bias1), .cfg_scale(scale),
        .cfg_shift(shift), .out_ready(out_ready), .out_valid(out_valid),
        .out_col0(out_col0), .out_col1(out_col1),
        .almost_full(almost_full), .overflow(overflow),
        .sat_count(sat_count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag,
                       input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    // Scoreboard: compare head of queue whenever a pop happens.
    always @(negedge clk) begin
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $error("FAIL unexpected_out: got %0d,%0d want none",
                       $signed(out_col0), $signed(out_col1));
            end else begin
                logic [15:0] e;
                e = q.pop_front();
                chk("out_col0", $signed(out_col0), $signed(e[7:0]));
                chk("out_col1", $signed(out_col1), $signed(e[15:8]));
            end
        end
    end

    task automatic send(input int a0, input int a1, input logic [1:0] m,
                        input int b0, input int b1,
                        input int sc, input int sh);
        acc0     = a0;
        acc1     = a1;
        mode     = m;
        bias0    = b0;
        bias1    = b1;
        scale    = 16'(sc);
        shift    = 5'(sh);
        valid_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid_in = 1'b0;
    endtask

    task automatic expect_out(input int e0, input int e1);
        q.push_back({8'(e1), 8'(e0)});
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (q.size() != 0 && n < 40) begin
            step();
            n++;
        end
        chk(tag, q.size(), 0);
    endtask

    initial begin
        int sat_exp;
`ifdef POST_ACC_SAT_COUNT_EN
        sat_exp = 2;
`else
        sat_exp = 0;
`endif
        reset = 1'b1; clear = 1'b0; valid_in = 1'b0; out_ready = 1'b1;
        acc0 = '0; acc1 = '0; bias0 = '0; bias1 = '0;
        mode = '0; scale = 16'd1; shift = '0;
        repeat (3) step();
        reset = 1'b0;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_col0", $signed(out_col0), 0);
        chk("rst_out_col1", $signed(out_col1), 0);
        chk("rst_almost_full", almost_full, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_sat_count", sat_count, 0);

        // passthrough with latency check
        expect_out(100, -50);
        send(100, -50, 2'b00, 0, 0, 1, 0);
        step();
        step();
        chk("lat_n2_valid", out_valid, 0);
        step();
        chk("lat_n3_valid", out_valid, 1);
        drain("drain_pass");

        // saturation
        expect_out(127, -128);
        send(1000, -1000, 2'b00, 0, 0, 1, 0);
        drain("drain_sat");
        step();
        chk("sat_count", sat_count, sat_exp);

        // activations and rounding, config changing every beat
        expect_out(0, 25);
        send(-10, 20, 2'b01, 5, 5, 1, 0);
        expect_out(-8, 64);
        send(-64, 64, 2'b10, 0, 0, 1, 0);
        expect_out(-1, 0);
        send(-1, 0, 2'b10, 0, 0, 1, 0);
        expect_out(3, -2);
        send(5, -5, 2'b00, 0, 0, 1, 1);
        expect_out(2, 0);
        send(3, 0, 2'b00, 0, 0, 3, 2);
        expect_out(-5, 0);
        send(-40, 7, 2'b11, 0, -7, 1, 3);
        drain("drain_math");

        // backpressure and overflow
        out_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            if (i <= 4)
                expect_out(i, -i);
            send(i, -i, 2'b00, 0, 0, 1, 0);
            if (i == 3)
                chk("af_edge3", almost_full, 0);
            if (i == 4)
                chk("af_edge4", almost_full, 1);
        end
        step();
        chk("ovf_edge7", overflow, 0);
        step();
        chk("ovf_edge8", overflow, 1);
        chk("hold_col0_a", $signed(out_col0), 1);
        step();
        chk("hold_col0_b", $signed(out_col0), 1);
        chk("hold_valid", out_valid, 1);
        out_ready = 1'b1;
        drain("drain_bp");
        step();
        chk("bp_empty", out_valid, 0);
        chk("ovf_sticky", overflow, 1);

        // flush with clear, then with reset
        for (int k = 0; k < 2; k++) begin
            out_ready = 1'b0;
            send(11, 12, 2'b00, 0, 0, 1, 0);
            step();
            send(13, 14, 2'b00, 0, 0, 1, 0);
            send(15, 16, 2'b00, 0, 0, 1, 0);
            chk("fl_pre_valid", out_valid, 1);
            acc0 = 32'd17;
            valid_in = 1'b1;
            if (k == 0)
                clear = 1'b1;
            else
                reset = 1'b1;
            step();
            clear = 1'b0;
            reset = 1'b0;
            valid_in = 1'b0;
            chk("fl_valid", out_valid, 0);
            chk("fl_almost_full", almost_full, 0);
            chk("fl_overflow", overflow, 0);
            chk("fl_sat_count", sat_count, 0);
            out_ready = 1'b1;
            for (int j = 0; j < 6; j++) begin
                step();
                chk("fl_no_output", out_valid, 0);
            end
            if (k == 0) begin
                out_ready = 1'b0;
                for (int i = 0; i < 4; i++)
                    send(1, 1, 2'b00, 0, 0, 1, 0);
                repeat (4) step();
                chk("fl_refill_ovf", overflow, 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/post_acc_quantizer.md
Name: post_acc_quantizer

Overview:
- Stage directly downstream of the accumulator. Consumes the 32-bit signed two-column accumulator results and their valid strobe.
- Applies per-column bias, a selectable activation, and fixed-point requantization (scale, round, shift, saturate) to int8.
- Buffers results in a small first-word-fall-through (FWFT) FIFO with a ready/valid output, for the unified-buffer writeback logic.
- The accumulator cannot stall, so the compute pipeline never stalls. Backpressure is absorbed by the FIFO and signalled upstream via almost_full.

Parameters:
FIFO_DEPTH, 4, output FIFO entries (power of two, >=4)
SHIFT_W, 5, width of cfg_shift (max right shift 31)

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
clear  in  1  synchronous flush: drops in-flight beats, empties FIFO, clears overflow and sat_count
valid_in  in  1  accumulator result valid
acc_col0_in  in  32  signed column-0 accumulator result
acc_col1_in  in  32  signed column-1 accumulator result
cfg_act_mode  in  2  00 none, 01 ReLU, 10 leaky ReLU (neg >>>3), 11 treated as none
cfg_bias0  in  32  signed bias, column 0
cfg_bias1  in  32  signed bias, column 1
cfg_scale  in  16  unsigned multiplier
cfg_shift  in  SHIFT_W  right-shift amount after scaling
out_ready  in  1  consumer accepts head entry
out_valid  out  1  FIFO non-empty
out_col0  out  8  signed int8 result, column 0
out_col1  out  8  signed int8 result, column 1
almost_full  out  1  (FIFO count + valid pipeline stages) >= FIFO_DEPTH
overflow  out  1  sticky: a result was dropped on a full FIFO
sat_count  out  16  saturating lane count (see Optional Feature)

Behaviour:
- Reset:
  - All stage valids are 0; FIFO pointers and count are 0.
  - out_valid=0, out_col0/1=0, almost_full=0, overflow=0, sat_count=0.
- clear: identical effect to reset, except config ports are unaffected. If clear and valid_in are both high in a cycle, clear wins and the beat is discarded.
- Pipeline: three registered stages, non-stallable. cfg_* is sampled together with the beat at S1 and carried along with it, so a config change affects only later beats.
  - S1: sum = acc + bias, sign-extended to 33 bits (no overflow possible).
  - S2, activation on the 33-bit value:
    - none: passthrough.
    - ReLU: negative -> 0.
    - leaky: negative -> arithmetic shift right by 3 (floor); non-negative unchanged.
  - S3, requantize:
    - prod = act * {0,cfg_scale}, 50-bit signed.
    - If cfg_shift>0, add 1<<(cfg_shift-1) (round half up); then arithmetic shift right by cfg_shift.
    - Saturate to [-128,127].
- Latency:
  - A beat sampled at edge N is written to the FIFO at edge N+3.
  - With an empty FIFO, out_valid and data are visible after edge N+3.
  - Back-to-back beats give one result per cycle.
- FIFO:
  - FWFT. A pop occurs on a rising edge with out_valid && out_ready. out_* hold steady while out_valid && !out_ready.
  - Push and pop in the same cycle on a full FIFO: both succeed, count unchanged.
  - Push on a full FIFO without a pop: result dropped, overflow set at that edge and held until reset or clear.
  - Pop on empty: no effect.
  - Pointers wrap modulo FIFO_DEPTH.
- almost_full is combinational from registered state. If upstream withholds valid_in while almost_full is high, overflow can never occur.
- Columns are processed identically and in lockstep; a FIFO entry always holds both columns of one beat.

Optional Feature:
- Macro: POST_ACC_SAT_COUNT_EN.
- Defined: sat_count increments by the number of lanes (0, 1 or 2) that clipped in each valid S3 beat, whether or not the beat is later dropped. The count saturates at 0xFFFF and is cleared by reset or clear.
- Undefined: the counter logic is omitted and sat_count is tied to 0.

Test Plan:
- Passthrough: mode 00, bias 0, scale 1, shift 0, acc (100,-50) at edge N -> out (100,-50), out_valid high after edge N+3.
- Saturation: acc (1000,-1000), scale 1, shift 0 -> out (127,-128); with POST_ACC_SAT_COUNT_EN, sat_count=2.
- Activations:
  - Mode 01, bias (5,5), acc (-10,20) -> (0,25).
  - Mode 10, bias 0, acc (-64,64) -> (-8,64).
  - Mode 10, acc (-1,0) -> (-1,0).
- Rounding:
  - Scale 1, shift 1, acc (5,-5) -> (3,-2).
  - Scale 3, shift 2, acc (3,0) -> (2,0).
- Backpressure, FIFO_DEPTH=4:
  - Setup: out_ready=0, 6 consecutive beats with values 1..6.
  - almost_full asserts after edge 4, with 1 queued and 3 in flight.
  - overflow rises at the 5th write edge.
  - Then out_ready=1 -> outputs 1,2,3,4 in order, then out_valid=0.
- Flush: clear asserted while 2 beats are in S1/S2 and 1 is in the FIFO -> next cycle out_valid=0, almost_full=0, overflow=0, and no later output appears; the same check applies with reset in place of clear.
